// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_if
// Purpose  : Bundles the ALU/load handshakes, scoreboard and RF write port.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_stage_if #(
  parameter int DEPTH = 4
);
  localparam int c_cw = $clog2(DEPTH) + 1;

  logic            alu_valid;
  logic            alu_ready;
  logic [3:0]      alu_rd;
  logic [31:0]     alu_data;

  logic            ld_valid;
  logic            ld_ready;
  logic [3:0]      ld_rd;
  logic [31:0]     ld_data;

  logic            issue_ld_valid;
  logic [3:0]      issue_ld_rd;

  logic [15:0]     busy;
  logic [c_cw-1:0] ld_q_count;

  logic            rf_we;
  logic [3:0]      rf_waddr;
  logic [31:0]     rf_wdata;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output issue_ld_valid, issue_ld_rd,
    input  alu_ready, ld_ready, busy, ld_q_count,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  issue_ld_valid, issue_ld_rd,
    output alu_ready, ld_ready, busy, ld_q_count,
    output rf_we, rf_waddr, rf_wdata
  );
endinterface
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : Writeback merge of ALU results and queued load returns onto the
//            register-file write port, with a load busy scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  wb_stage_if.slave bus
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam int c_sw = $clog2(STARVE_MAX + 1);

  localparam logic [c_cw-1:0] c_depth      = c_cw'(DEPTH);
  localparam logic [c_sw-1:0] c_starve_max = c_sw'(STARVE_MAX);

  // Load-return queue storage and bookkeeping
  logic [3:0]      r_q_rd   [DEPTH];
  logic [31:0]     r_q_data [DEPTH];
  logic [c_aw-1:0] r_wptr;
  logic [c_aw-1:0] r_rptr;
  logic [c_cw-1:0] r_count;
  logic [c_sw-1:0] r_starve;

  logic [15:0]     r_busy;
  logic            r_rf_we;
  logic [3:0]      r_rf_waddr;
  logic [31:0]     r_rf_wdata;

  logic            w_ld_ready;
  logic            w_alu_ready;
  logic            w_q_empty;
  logic            w_alu_sel;
  logic            w_pop;
  logic            w_push;
  logic [3:0]      w_head_rd;
  logic [31:0]     w_head_data;
  logic [15:0]     w_busy_nxt;

  // Both ready signals depend on state only, never on the incoming valids.
  assign w_ld_ready  = (r_count != c_depth);
  assign w_alu_ready = (r_starve != c_starve_max);
  assign w_q_empty   = (r_count == '0);

  assign w_alu_sel   = bus.alu_valid && w_alu_ready;
  assign w_pop       = !w_alu_sel && !w_q_empty;
  assign w_push      = bus.ld_valid && w_ld_ready;

  assign w_head_rd   = r_q_rd[r_rptr];
  assign w_head_data = r_q_data[r_rptr];

  // Clear first so a same-edge issue to the popped register stays busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop) begin
      w_busy_nxt[w_head_rd] = 1'b0;
    end
    if (bus.issue_ld_valid && (bus.issue_ld_rd != 4'd0)) begin
      w_busy_nxt[bus.issue_ld_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_wptr]   <= bus.ld_rd;
      r_q_data[r_wptr] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_aw'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_aw'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Counts ALU wins over a waiting load; at the limit the ALU is held off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_pop || w_q_empty) begin
      r_starve <= '0;
    end else if (w_alu_sel) begin
      r_starve <= r_starve + c_sw'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Writes to r0 are consumed silently and leave the address/data untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= 4'd0;
      r_rf_wdata <= 32'd0;
    end else begin
      r_rf_we <= 1'b0;
      if (w_alu_sel) begin
        if (bus.alu_rd != 4'd0) begin
          r_rf_we    <= 1'b1;
          r_rf_waddr <= bus.alu_rd;
          r_rf_wdata <= bus.alu_data;
        end
      end else if (w_pop) begin
        if (w_head_rd != 4'd0) begin
          r_rf_we    <= 1'b1;
          r_rf_waddr <= w_head_rd;
          r_rf_wdata <= w_head_data;
        end
      end
    end
  end

  assign bus.alu_ready  = w_alu_ready;
  assign bus.ld_ready   = w_ld_ready;
  assign bus.busy       = r_busy;
  assign bus.ld_q_count = r_count;
  assign bus.rf_we      = r_rf_we;
  assign bus.rf_waddr   = r_rf_waddr;
  assign bus.rf_wdata   = r_rf_wdata;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Purpose  : Scoreboard bench for wb_stage against a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  wb_stage_if #(.DEPTH(DEPTH)) bus ();

  wb_stage #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } wr_t;

  // Reference model state
  wr_t         m_q[$];
  wr_t         exp_q[$];
  int          m_starve;
  logic [15:0] m_busy;
  logic        m_we;
  logic [3:0]  m_last_addr;
  logic [31:0] m_last_data;

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_starve    = 0;
    m_busy      = 16'd0;
    m_we        = 1'b0;
    m_last_addr = 4'd0;
    m_last_data = 32'd0;
  endtask

  // One clock edge of the writeback rules, applied to the inputs seen at that edge.
  task automatic model_step();
    wr_t e;
    bit  alu_win;
    bit  pop;
    int  qs;
    qs      = m_q.size();
    alu_win = bus.alu_valid && (m_starve != STARVE_MAX);
    pop     = !alu_win && (qs > 0);
    m_we    = 1'b0;
    e       = '0;
    if (alu_win) begin
      e.rd   = bus.alu_rd;
      e.data = bus.alu_data;
    end else if (pop) begin
      e = m_q.pop_front();
      m_busy[e.rd] = 1'b0;
    end
    if ((alu_win || pop) && (e.rd != 4'd0)) begin
      m_we        = 1'b1;
      m_last_addr = e.rd;
      m_last_data = e.data;
      exp_q.push_back(e);
    end
    if (pop || qs == 0) m_starve = 0;
    else                m_starve = m_starve + 1;
    if (bus.ld_valid && qs != DEPTH) begin
      e.rd   = bus.ld_rd;
      e.data = bus.ld_data;
      m_q.push_back(e);
    end
    if (bus.issue_ld_valid && bus.issue_ld_rd != 4'd0) begin
      m_busy[bus.issue_ld_rd] = 1'b1;
    end
  endtask

  // Drive one cycle of inputs; an ALU result stalled by alu_ready=0 is held.
  task automatic cycle(input int av, input int ard, input logic [31:0] ad,
                       input int lv, input int lrd, input logic [31:0] ld,
                       input int iv, input int ird);
    if (!(rst_n && bus.alu_valid && m_starve == STARVE_MAX)) begin
      bus.alu_valid = (av != 0);
      bus.alu_rd    = 4'(ard);
      bus.alu_data  = ad;
    end
    bus.ld_valid       = (lv != 0);
    bus.ld_rd          = 4'(lrd);
    bus.ld_data        = ld;
    bus.issue_ld_valid = (iv != 0);
    bus.issue_ld_rd    = 4'(ird);
    @(posedge clk);
    if (rst_n) model_step();
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 32'd0, 0, 0, 32'd0, 0, 0);
  endtask

  // Monitor: compares every output against the model on the falling edge.
  always @(negedge clk) begin
    wr_t e;
    if (!done) begin
      chk("rf_we", 64'(bus.rf_we), 64'(m_we));
      if (bus.rf_we) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rf_write: got write r%0d=0x%0h required none", bus.rf_waddr, bus.rf_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("rf_waddr", 64'(bus.rf_waddr), 64'(e.rd));
          chk("rf_wdata", 64'(bus.rf_wdata), 64'(e.data));
        end
      end else begin
        chk("rf_waddr_hold", 64'(bus.rf_waddr), 64'(m_last_addr));
        chk("rf_wdata_hold", 64'(bus.rf_wdata), 64'(m_last_data));
      end
      chk("alu_ready",  64'(bus.alu_ready),  64'(m_starve != STARVE_MAX));
      chk("ld_ready",   64'(bus.ld_ready),   64'(m_q.size() != DEPTH));
      chk("busy",       64'(bus.busy),       64'(m_busy));
      chk("ld_q_count", 64'(bus.ld_q_count), 64'(m_q.size()));
    end
  end

  initial begin
    int pa;
    int pl;
    rst_n              = 1'b0;
    bus.alu_valid      = 1'b1;
    bus.alu_rd         = 4'd5;
    bus.alu_data       = 32'h11;
    bus.ld_valid       = 1'b0;
    bus.ld_rd          = 4'd0;
    bus.ld_data        = 32'd0;
    bus.issue_ld_valid = 1'b0;
    bus.issue_ld_rd    = 4'd0;
    model_reset();

    // Reset held with an ALU result pending
    repeat (3) @(posedge clk);
    #2;
    chk("reset_rf_we",     64'(bus.rf_we),      64'(0));
    chk("reset_rf_waddr",  64'(bus.rf_waddr),   64'(0));
    chk("reset_rf_wdata",  64'(bus.rf_wdata),   64'(0));
    chk("reset_busy",      64'(bus.busy),       64'(0));
    chk("reset_count",     64'(bus.ld_q_count), 64'(0));
    chk("reset_alu_ready", 64'(bus.alu_ready),  64'(1));
    chk("reset_ld_ready",  64'(bus.ld_ready),   64'(1));
    rst_n = 1'b1;

    cycle(1, 5, 32'h11, 0, 0, 32'd0, 0, 0);
    chk("first_alu_we",   64'(bus.rf_we),    64'(1));
    chk("first_alu_addr", 64'(bus.rf_waddr), 64'(5));
    chk("first_alu_data", 64'(bus.rf_wdata), 64'(32'h11));

    // Issue then return a load to r7
    cycle(0, 0, 32'd0, 0, 0, 32'd0, 1, 7);
    chk("busy7_set", 64'(bus.busy[7]), 64'(1));
    cycle(0, 0, 32'd0, 1, 7, 32'hDEADBEEF, 0, 0);
    chk("ld7_not_bypassed", 64'(bus.rf_we), 64'(0));
    cycle(0, 0, 32'd0, 0, 0, 32'd0, 0, 0);
    chk("ld7_we",    64'(bus.rf_we),    64'(1));
    chk("ld7_addr",  64'(bus.rf_waddr), 64'(7));
    chk("ld7_data",  64'(bus.rf_wdata), 64'(32'hDEADBEEF));
    chk("busy7_clr", 64'(bus.busy[7]),  64'(0));
    idle(2);

    // Fill the queue under continuous ALU traffic, then let starvation drain it
    for (int i = 0; i < 4; i++) cycle(1, 9 + i, 32'hA000 + i, 1, 1 + i, 32'hB000 + i, 0, 0);
    chk("full_ld_ready",  64'(bus.ld_ready),   64'(0));
    chk("full_count",     64'(bus.ld_q_count), 64'(4));
    chk("full_alu_ready", 64'(bus.alu_ready),  64'(0));
    for (int i = 0; i < 14; i++) cycle(1, 10, 32'hC000 + i, 0, 0, 32'd0, 0, 0);
    idle(3);

    // r0 destinations are consumed without a write
    cycle(1, 0, 32'h1234, 0, 0, 32'd0, 0, 0);
    cycle(0, 0, 32'd0, 1, 0, 32'h5678, 1, 0);
    idle(3);
    chk("r0_busy", 64'(bus.busy[0]), 64'(0));

    // Pop clearing r3 on the same edge as a new issue to r3
    cycle(0, 0, 32'd0, 0, 0, 32'd0, 1, 3);
    cycle(0, 0, 32'd0, 1, 3, 32'h33, 0, 0);
    cycle(0, 0, 32'd0, 0, 0, 32'd0, 1, 3);
    chk("busy3_set_wins", 64'(bus.busy[3]), 64'(1));
    cycle(0, 0, 32'd0, 1, 3, 32'h333, 0, 0);
    idle(3);

    // Asynchronous reset with three queued loads and r4..r7 busy
    for (int i = 4; i < 8; i++) cycle(0, 0, 32'd0, 0, 0, 32'd0, 1, i);
    for (int i = 0; i < 3; i++) cycle(1, 9, 32'hE000 + i, 1, 12 + i, 32'hF000 + i, 0, 0);
    chk("pre_reset_busy",  64'(bus.busy),       64'(16'h00F0));
    chk("pre_reset_count", 64'(bus.ld_q_count), 64'(3));
    rst_n = 1'b0;
    #1;
    chk("async_rf_we", 64'(bus.rf_we),      64'(0));
    chk("async_busy",  64'(bus.busy),       64'(0));
    chk("async_count", 64'(bus.ld_q_count), 64'(0));
    model_reset();
    #1;
    idle(2);
    rst_n = 1'b1;
    idle(5);

    // Randomized traffic with phases of heavy, medium and light ALU load
    for (int i = 0; i < 900; i++) begin
      case ((i / 100) % 3)
        0:       pa = 90;
        1:       pa = 45;
        default: pa = 10;
      endcase
      pl = ((i / 150) % 2 == 0) ? 70 : 30;
      cycle(int'($urandom_range(0, 99) < pa), int'($urandom_range(0, 15)), $urandom,
            int'($urandom_range(0, 99) < pl), int'($urandom_range(0, 15)), $urandom,
            int'($urandom_range(0, 99) < 30), int'($urandom_range(0, 15)));
    end
    idle(12);

    done = 1'b1;
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
